sdram_test_master: RTL and testbench
====================================

SDRAM_TEST_MASTER -- requirements
Module: sdram_test_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, byte-agnostic word address width of the controller port.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first word address tested.
REQ-004 SHALL have parameter NUM_WORDS, default 256, words per pass (1..2^ADDR_WIDTH).
REQ-005 SHALL have parameter SEED, default 16'hA5C3, pattern XOR key.
REQ-006 SHALL have parameter TIMEOUT, default 4096, max cycles waiting on any single handshake.
REQ-007 Ports: clk in 1 clock; reset in 1 synchronous active-low reset (one clock, reset asserted when low).
REQ-008 Ports: start in 1 pulse begins a pass; busy out 1; done out 1 one-cycle pulse at pass end; pass out 1 last pass clean; timeout out 1 last pass aborted.
REQ-009 Ports: error_count out 16 mismatches in last pass; fail_addr out ADDR_WIDTH first mismatching address; fail_data out DATA_WIDTH data read at fail_addr.
REQ-010 Ports: m_axi_awaddr out ADDR_WIDTH; m_axi_awvalid out 1; m_axi_awready in 1; m_axi_wdata out DATA_WIDTH; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-011 Ports: m_axi_araddr out ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_rdata in DATA_WIDTH; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-012 States SHALL be IDLE, WR, RD_ADDR, RD_DATA, FINISH.
REQ-013 IDLE: start high at a rising edge SHALL move to WR next cycle, clear error_count/pass/timeout/fail_*, index=0, busy=1.
REQ-014 Address for index i SHALL be (BASE_ADDR+i) mod 2^ADDR_WIDTH; pattern SHALL be (address[DATA_WIDTH-1:0]) XOR SEED.
REQ-015 WR: awvalid and wvalid SHALL assert together in the first WR cycle, with awaddr/wdata stable until both awready and wready are high in the same cycle.
REQ-016 On that joint handshake both valids SHALL drop or advance to next word next cycle; awready or wready alone SHALL NOT complete a write.
REQ-017 After write of index NUM_WORDS-1, index SHALL reset to 0 and state go to RD_ADDR.
REQ-018 RD_ADDR: arvalid high, araddr stable until arready; on handshake go to RD_DATA, arvalid low next cycle; one read outstanding max.
REQ-019 RD_DATA: rready SHALL be high; on rvalid&rready compare rdata to pattern; mismatch increments error_count (saturating at 16'hFFFF), first mismatch latches fail_addr/fail_data.
REQ-020 After compare of index NUM_WORDS-1 go to FINISH; otherwise next index, RD_ADDR.
REQ-021 rready SHALL be low outside RD_DATA; rvalid outside RD_DATA SHALL be ignored.
REQ-022 Watchdog SHALL count cycles a valid (or rready) is held without completion; reaching TIMEOUT SHALL drop all valids, set timeout=1, pass=0, go to FINISH.
REQ-023 FINISH: done=1 for exactly one cycle, busy=0, pass=(error_count==0 && !timeout), return to IDLE.
REQ-024 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-025 Results SHALL hold until the next accepted start.

Reset
REQ-026 On reset low at a rising edge: state IDLE; all valids, rready, busy, done, pass, timeout low; error_count, fail_addr, fail_data, index, watchdog zero.
REQ-027 Reset mid-transaction SHALL drop valids on the following edge regardless of pending ready.

Structure
REQ-028 ADDR_WIDTH/DATA_WIDTH defaults and the state encoding SHALL live in shared package sdram_pkg used with sdram_controller.
REQ-029 Pattern generation SHALL be sub-module sdram_pattern_gen (address in, pattern out, SEED parameter); watchdog stays inline.

Verification
REQ-030 Bench with sdram_controller + sdr model, NUM_WORDS=4, BASE_ADDR=1 -> four writes to 1..4 with data 16'hA5C2,16'hA5C1,16'hA5C0,16'hA5C7, reads return same, done pulse, pass=1, error_count=0.
REQ-031 Stub responder raises awready 3 cycles before wready -> no write completes until both high; awaddr/wdata unchanged across all waiting cycles.
REQ-032 Stub corrupts read of address 3 to 16'h0000 -> error_count=1, fail_addr=3, fail_data=16'h0000, pass=0.
REQ-033 Stub never asserts arready, TIMEOUT=16 -> arvalid low after 16 cycles, timeout=1, done pulse, pass=0.
REQ-034 BASE_ADDR=2^25-2, NUM_WORDS=4 -> addresses 0x1FFFFFE,0x1FFFFFF,0,1 in order.
REQ-035 reset low during WR with awvalid held -> all valids low next edge, busy=0; start after release runs a full clean pass.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller and its built-in test master.
package sdram_pkg;

  // Default port geometry of the SDRAM controller word interface.
  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  // Test master state encoding, kept as plain constants for legacy users.
  localparam int         ST_W        = 3;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_RD_ADDR  = 3'd2;
  localparam logic [2:0] ST_RD_DATA  = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  // Result flags and mismatch counter reported after each pass.
  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [15:0] err_cnt;
  } tm_status_t;

  // Mismatch counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Test data for a word address: low address bits XORed with a fixed key.
module sdram_pattern_gen #(
  parameter int                    ADDR_WIDTH = 25,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(16'hA5C3)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] pattern
);

  // Cast truncates wide addresses and zero-extends narrow ones.
  assign pattern = DATA_WIDTH'(addr) ^ SEED;

endmodule

// File: rtl/sdram_test_master.sv
// Write-then-read-back memory test master driving an AXI-lite style
// word port. One write or one read outstanding at a time, with a
// per-handshake watchdog so a stuck slave ends the pass instead of hanging.
module sdram_test_master
  import sdram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = SDRAM_ADDR_W,
  parameter int                    DATA_WIDTH = SDRAM_DATA_W,
  parameter longint unsigned       BASE_ADDR  = 0,
  parameter longint unsigned       NUM_WORDS  = 256,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(16'hA5C3),
  parameter int                    TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [31:0]           WD_LAST  = 32'(TIMEOUT - 1);

  logic [ST_W-1:0]       state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdog_q, wdog_d;
  tm_status_t            stat_q, stat_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_pat;
  logic                  last_word;
  logic                  wd_hit;

  // Address wraps naturally at 2^ADDR_WIDTH through the adder width.
  assign cur_addr  = BASE_A + idx_q;
  assign last_word = (idx_q == LAST_IDX);
  assign wd_hit    = (wdog_q >= WD_LAST);

  sdram_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SEED       (SEED)
  ) u_pat (
    .addr    (cur_addr),
    .pattern (cur_pat)
  );

  // Handshake outputs are pure state decodes, so a reset or timeout that
  // leaves the bus states drops every valid on the very next edge.
  assign m_axi_awaddr  = cur_addr;
  assign m_axi_wdata   = cur_pat;
  assign m_axi_awvalid = (state_q == ST_WR);
  assign m_axi_wvalid  = (state_q == ST_WR);
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arvalid = (state_q == ST_RD_ADDR);
  assign m_axi_rready  = (state_q == ST_RD_DATA);

  assign busy        = (state_q == ST_WR) || (state_q == ST_RD_ADDR) ||
                       (state_q == ST_RD_DATA);
  assign done        = (state_q == ST_FINISH);
  assign pass        = stat_q.pass;
  assign timeout     = stat_q.timeout;
  assign error_count = stat_q.err_cnt;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

  // Sequencer: write every word, then read and compare every word.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    stat_d      = stat_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WR;
          idx_d       = '0;
          wdog_d      = '0;
          stat_d      = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end

      ST_WR: begin
        // Address and data travel together; one ready alone is not enough.
        if (m_axi_awready && m_axi_wready) begin
          wdog_d = '0;
          if (last_word) begin
            idx_d   = '0;
            state_d = ST_RD_ADDR;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end else if (wd_hit) begin
          state_d        = ST_FINISH;
          wdog_d         = '0;
          stat_d.timeout = 1'b1;
          stat_d.pass    = 1'b0;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end

      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          wdog_d  = '0;
          state_d = ST_RD_DATA;
        end else if (wd_hit) begin
          state_d        = ST_FINISH;
          wdog_d         = '0;
          stat_d.timeout = 1'b1;
          stat_d.pass    = 1'b0;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end

      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          wdog_d = '0;
          if (m_axi_rdata != cur_pat) begin
            // Only the first mismatch of a pass is captured.
            if (stat_q.err_cnt == 16'd0) begin
              fail_addr_d = cur_addr;
              fail_data_d = m_axi_rdata;
            end
            stat_d.err_cnt = sat_inc16(stat_q.err_cnt);
          end
          if (last_word) begin
            state_d     = ST_FINISH;
            stat_d.pass = (stat_d.err_cnt == 16'd0) && !stat_q.timeout;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = ST_RD_ADDR;
          end
        end else if (wd_hit) begin
          state_d        = ST_FINISH;
          wdog_d         = '0;
          stat_d.timeout = 1'b1;
          stat_d.pass    = 1'b0;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end

      // Single-cycle done; a start seen here is deliberately dropped.
      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wdog_q      <= '0;
      stat_q      <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      stat_q      <= stat_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

endmodule

// File: tb/tb_sdram_test_master.sv
// Directed bench for sdram_test_master: table of responder behaviours plus
// hand sequences for start filtering, reset mid-write and address wrap.
module tb_sdram_test_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  // Responder behaviour controls for instance A.
  logic split_mode   = 1'b0;
  logic corrupt_mode = 1'b0;
  logic noar_mode    = 1'b0;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: BASE 1, 4 words, TIMEOUT 16 -------------
  logic        busy_a, done_a, pass_a, timeout_a;
  logic [15:0] err_a;
  logic [24:0] faddr_a;
  logic [15:0] fdata_a;
  logic [24:0] awaddr_a, araddr_a;
  logic [15:0] wdata_a, rdata_a;
  logic        awvalid_a, awready_a, wvalid_a, wready_a;
  logic        arvalid_a, arready_a, rvalid_a, rready_a;

  sdram_test_master #(
    .BASE_ADDR (1), .NUM_WORDS (4), .TIMEOUT (16)
  ) dut_a (
    .clk (clk), .reset (reset), .start (start_a),
    .busy (busy_a), .done (done_a), .pass (pass_a), .timeout (timeout_a),
    .error_count (err_a), .fail_addr (faddr_a), .fail_data (fdata_a),
    .m_axi_awaddr (awaddr_a), .m_axi_awvalid (awvalid_a), .m_axi_awready (awready_a),
    .m_axi_wdata (wdata_a), .m_axi_wvalid (wvalid_a), .m_axi_wready (wready_a),
    .m_axi_araddr (araddr_a), .m_axi_arvalid (arvalid_a), .m_axi_arready (arready_a),
    .m_axi_rdata (rdata_a), .m_axi_rvalid (rvalid_a), .m_axi_rready (rready_a)
  );

  // Stub slave A: optional awready-before-wready, read corruption, dead arready.
  int          aw_cnt = 0;
  logic [15:0] mem_a [16];
  logic        rv_a = 1'b0;
  logic [15:0] rd_a = '0;
  int          wr_n_a = 0;
  logic [24:0] wlog_addr_a [64];
  logic [15:0] wlog_data_a [64];

  assign awready_a = split_mode ? (awvalid_a && aw_cnt >= 1) : 1'b1;
  assign wready_a  = split_mode ? (awvalid_a && aw_cnt >= 4) : 1'b1;
  assign arready_a = !noar_mode;
  assign rvalid_a  = rv_a;
  assign rdata_a   = rd_a;

  always @(posedge clk) begin
    if (awvalid_a && wvalid_a && awready_a && wready_a) begin
      mem_a[awaddr_a[3:0]]      <= wdata_a;
      wlog_addr_a[wr_n_a % 64]  <= awaddr_a;
      wlog_data_a[wr_n_a % 64]  <= wdata_a;
      wr_n_a                    <= wr_n_a + 1;
      aw_cnt                    <= 0;
    end else if (awvalid_a) aw_cnt <= aw_cnt + 1;
    else aw_cnt <= 0;
    if (rv_a && rready_a) rv_a <= 1'b0;
    if (arvalid_a && arready_a) begin
      rv_a <= 1'b1;
      rd_a <= (corrupt_mode && araddr_a == 25'd3) ? 16'h0000 : mem_a[araddr_a[3:0]];
    end
  end

  // Bus-rule monitors on instance A.
  int          unstable_a = 0;
  int          skew_a     = 0;
  int          arv_run    = 0;
  int          arv_max    = 0;
  logic        pend_q     = 1'b0;
  logic [24:0] pa_q       = '0;
  logic [15:0] pw_q       = '0;

  always @(posedge clk) begin
    if (pend_q && awvalid_a && (awaddr_a !== pa_q || wdata_a !== pw_q))
      unstable_a <= unstable_a + 1;
    if (awvalid_a !== wvalid_a) skew_a <= skew_a + 1;
    pend_q <= awvalid_a && !(awready_a && wready_a);
    pa_q   <= awaddr_a;
    pw_q   <= wdata_a;
    if (arvalid_a) begin
      arv_run <= arv_run + 1;
      if (arv_run + 1 > arv_max) arv_max <= arv_run + 1;
    end else arv_run <= 0;
  end

  // ---------------- instance B: address wrap at 2^25 ---------------------
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [15:0] err_b;
  logic [24:0] faddr_b;
  logic [15:0] fdata_b;
  logic [24:0] awaddr_b, araddr_b;
  logic [15:0] wdata_b, rdata_b;
  logic        awvalid_b, wvalid_b, arvalid_b, rvalid_b, rready_b;

  sdram_test_master #(
    .BASE_ADDR ((64'd1 << 25) - 2), .NUM_WORDS (4)
  ) dut_b (
    .clk (clk), .reset (reset), .start (start_b),
    .busy (busy_b), .done (done_b), .pass (pass_b), .timeout (timeout_b),
    .error_count (err_b), .fail_addr (faddr_b), .fail_data (fdata_b),
    .m_axi_awaddr (awaddr_b), .m_axi_awvalid (awvalid_b), .m_axi_awready (1'b1),
    .m_axi_wdata (wdata_b), .m_axi_wvalid (wvalid_b), .m_axi_wready (1'b1),
    .m_axi_araddr (araddr_b), .m_axi_arvalid (arvalid_b), .m_axi_arready (1'b1),
    .m_axi_rdata (rdata_b), .m_axi_rvalid (rvalid_b), .m_axi_rready (rready_b)
  );

  logic [15:0] mem_b [16];
  logic        rv_b = 1'b0;
  logic [15:0] rd_b = '0;
  int          wr_n_b = 0;
  logic [24:0] wlog_addr_b [8];
  logic [15:0] wlog_data_b [8];

  assign rvalid_b = rv_b;
  assign rdata_b  = rd_b;

  always @(posedge clk) begin
    if (awvalid_b && wvalid_b) begin
      mem_b[awaddr_b[3:0]]    <= wdata_b;
      wlog_addr_b[wr_n_b % 8] <= awaddr_b;
      wlog_data_b[wr_n_b % 8] <= wdata_b;
      wr_n_b                  <= wr_n_b + 1;
    end
    if (rv_b && rready_b) rv_b <= 1'b0;
    if (arvalid_b) begin
      rv_b <= 1'b1;
      rd_b <= mem_b[araddr_b[3:0]];
    end
  end

  // ---------------- helpers ----------------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start on A and wait (bounded) for the done pulse.
  task automatic run_a(output bit ok);
    ok = 1'b0;
    tick(); start_a = 1'b1;
    tick(); start_a = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done_a) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  typedef struct {
    string       name;
    bit          split;
    bit          corrupt;
    bit          noar;
    bit          exp_pass;
    bit          exp_timeout;
    logic [15:0] exp_err;
    logic [24:0] exp_faddr;
    logic [15:0] exp_fdata;
  } vec_t;

  vec_t        tbl [4];
  logic [24:0] exp_wa [4];
  logic [15:0] exp_wd [4];
  logic [24:0] exp_wa_b [4];
  logic [15:0] exp_wd_b [4];

  initial begin
    bit ok;
    int w0;

    tbl[0] = '{"clean",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 25'd0, 16'h0000};
    tbl[1] = '{"split",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 25'd0, 16'h0000};
    tbl[2] = '{"corrupt", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 25'd3, 16'h0000};
    tbl[3] = '{"noar",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 25'd0, 16'h0000};
    exp_wa   = '{25'd1, 25'd2, 25'd3, 25'd4};
    exp_wd   = '{16'hA5C2, 16'hA5C1, 16'hA5C0, 16'hA5C7};
    exp_wa_b = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000, 25'h0000001};
    exp_wd_b = '{16'h5A3D, 16'h5A3C, 16'hA5C3, 16'hA5C2};

    // Reset state.
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_flags", {busy_a, done_a, pass_a, timeout_a}, 4'b0000);
    chk("rst_valids", {awvalid_a, wvalid_a, arvalid_a, rready_a}, 4'b0000);
    chk("rst_err", err_a, 16'd0);
    chk("rst_fail", {faddr_a, fdata_a}, 41'd0);
    reset = 1'b1;
    tick();

    // Table of responder behaviours.
    for (int v = 0; v < 4; v++) begin
      split_mode   = tbl[v].split;
      corrupt_mode = tbl[v].corrupt;
      noar_mode    = tbl[v].noar;
      w0 = wr_n_a;
      run_a(ok);
      chk({tbl[v].name, "_done"}, ok, 1'b1);
      chk({tbl[v].name, "_busy"}, busy_a, 1'b0);
      chk({tbl[v].name, "_pass"}, pass_a, tbl[v].exp_pass);
      chk({tbl[v].name, "_timeout"}, timeout_a, tbl[v].exp_timeout);
      chk({tbl[v].name, "_err"}, err_a, tbl[v].exp_err);
      chk({tbl[v].name, "_faddr"}, faddr_a, tbl[v].exp_faddr);
      chk({tbl[v].name, "_fdata"}, fdata_a, tbl[v].exp_fdata);
      chk({tbl[v].name, "_arvalid_fin"}, arvalid_a, 1'b0);
      chk({tbl[v].name, "_writes"}, wr_n_a - w0, 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_wa%0d", tbl[v].name, i), wlog_addr_a[(w0 + i) % 64], exp_wa[i]);
        chk($sformatf("%s_wd%0d", tbl[v].name, i), wlog_data_a[(w0 + i) % 64], exp_wd[i]);
      end
      tick();
      chk({tbl[v].name, "_done_1cyc"}, done_a, 1'b0);
      repeat (3) tick();
      chk({tbl[v].name, "_hold"}, {pass_a, timeout_a, err_a}, {tbl[v].exp_pass, tbl[v].exp_timeout, tbl[v].exp_err});
    end
    split_mode = 1'b0; corrupt_mode = 1'b0; noar_mode = 1'b0;
    chk("timeout_arvalid_cycles", arv_max, 16);
    chk("split_stable", unstable_a, 0);
    chk("aw_w_together", skew_a, 0);

    // Start while busy is ignored; start during the done cycle is ignored.
    w0 = wr_n_a;
    tick(); start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick(); tick(); start_a = 1'b1;
    tick(); start_a = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done_a) begin ok = 1'b1; break; end
      tick();
    end
    chk("busy_start_done", ok, 1'b1);
    chk("busy_start_writes", wr_n_a - w0, 4);
    start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("finish_start_idle", busy_a, 1'b0);
    tick();
    chk("finish_start_idle2", busy_a, 1'b0);

    // Reset while a write is held waiting on wready.
    split_mode = 1'b1;
    w0 = wr_n_a;
    tick(); start_a = 1'b1;
    tick(); start_a = 1'b0;
    tick();
    chk("pre_rst_awvalid", awvalid_a, 1'b1);
    reset = 1'b0;
    tick();
    chk("rst_mid_valids", {awvalid_a, wvalid_a, arvalid_a}, 3'b000);
    chk("rst_mid_busy", busy_a, 1'b0);
    chk("rst_mid_nowrite", wr_n_a - w0, 0);
    reset = 1'b1;
    split_mode = 1'b0;
    w0 = wr_n_a;
    run_a(ok);
    chk("post_rst_done", ok, 1'b1);
    chk("post_rst_pass", {pass_a, timeout_a, err_a}, {1'b1, 1'b0, 16'd0});
    chk("post_rst_writes", wr_n_a - w0, 4);

    // Address wrap on instance B.
    tick(); start_b = 1'b1;
    tick(); start_b = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done_b) begin ok = 1'b1; break; end
      tick();
    end
    chk("wrap_done", ok, 1'b1);
    chk("wrap_pass", {pass_b, err_b}, {1'b1, 16'd0});
    chk("wrap_writes", wr_n_b, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_wa%0d", i), wlog_addr_b[i], exp_wa_b[i]);
      chk($sformatf("wrap_wd%0d", i), wlog_data_b[i], exp_wd_b[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
